lz77_decoder: RTL
=================

// Module: lz77_decoder
// PURPOSE
//  Reconstructs the original byte stream from LZ77 tokens (position, length, next_symbol)
//  produced by the LZ77 encoder. Keeps a circular history window of the last
//  DICTIONARY_DEPTH output bytes and emits decoded bytes one per cycle on a valid/ready stream.
//  Sits after the token deserializer and feeds the byte sink / CRC checker.
// PARAMETERS
//  DATA_WIDTH            8    symbol width in bits
//  DICTIONARY_DEPTH      512  history window size in bytes (power of 2)
//  DICTIONARY_DEPTH_LOG  9    log2(DICTIONARY_DEPTH)
//  LOOK_AHEAD_BUFF_DEPTH 66   max match length + 1
//  CNT_WIDTH             7    width of tok_length; 2**CNT_WIDTH > LOOK_AHEAD_BUFF_DEPTH
// PORTS
//  clk              in   1                       clock, all logic on rising edge
//  rst              in   1                       asynchronous, active-high reset
//  tok_valid        in   1                       token present
//  tok_ready        out  1                       token accepted when tok_valid & tok_ready
//  tok_position     in   DICTIONARY_DEPTH_LOG+1  match distance back, 1..DICTIONARY_DEPTH
//  tok_length       in   CNT_WIDTH               bytes to copy, 0..LOOK_AHEAD_BUFF_DEPTH-1
//  tok_next_symbol  in   DATA_WIDTH              literal emitted after the copy
//  tok_last         in   1                       last token of the block
//  out_valid        out  1                       decoded byte valid
//  out_ready        in   1                       sink accepts byte
//  out_data         out  DATA_WIDTH              decoded byte
//  out_last         out  1                       final byte of the block
//  err_token        out  1                       sticky: illegal distance seen
// BEHAVIOUR
//  - Reset: tok_ready=0 for the first cycle after release; out_valid=0, out_data=0, out_last=0,
//    err_token=0, wr_ptr=0, fill=0, FSM=IDLE. Reset mid-token abandons the token and clears history.
//  - FSM IDLE: tok_ready=1. On accept: latch token; length==0 -> LIT, else -> COPY with rd_ptr=wr_ptr-position
//    (mod DICTIONARY_DEPTH), remaining count = length.
//  - COPY: each advancing cycle reads history[rd_ptr], emits it, writes it at wr_ptr, and increments both
//    pointers (wrap mod DEPTH). Decrements the count; at 0 -> LIT.
//  - LIT: emit tok_next_symbol, write it to history, and increment wr_ptr. out_last = latched tok_last.
//    -> IDLE.
//  - Throughput: 1 byte/cycle while out_ready=1. Token-to-first-byte latency is 2 cycles (accept +
//    synchronous RAM read). Back-to-back tokens: tok_ready reasserts the cycle after the LIT byte is issued.
//  - Overlap: distance < length must replicate the repeating pattern. For distance 1, the RAM read
//    returns a stale byte, so the last-written byte is bypassed directly to the output.
//  - Backpressure: out_valid/out_data/out_last hold stable while out_valid & ~out_ready. Pointers, count,
//    and RAM writes advance only on a transfer. No byte is dropped or duplicated.
//  - fill saturates at DICTIONARY_DEPTH. If length>0 and (position==0 or position>fill), set err_token,
//    still emit length bytes read from the RAM (contents undefined), then the literal. err_token clears
//    only on rst.
//  - Arithmetic: pointers are DICTIONARY_DEPTH_LOG bits and wrap naturally. position==DICTIONARY_DEPTH
//    maps to rd_ptr=wr_ptr, the oldest byte.
//  - tok_* inputs are sampled only on accept and ignored otherwise.
// STRUCTURE
//  - Shared package lz77_pkg: the default parameter constants, FSM state encoding (IDLE/COPY/LIT),
//    and the token field widths shared with lz77_encoder.
//  - One sub-module, lz77_history_ram: simple dual-port, DICTIONARY_DEPTH x DATA_WIDTH, synchronous write,
//    1-cycle registered read, no reset on the array (infers BRAM).
//  - The top level holds the FSM, pointers, count, fill, bypass register, and output register.
// TESTING
//  1. Literals only: tokens (0,0,'A'),(0,0,'B'),(0,0,'C',last) -> out "ABC", out_last on 'C', err_token=0.
//  2. Copy: "ABC" then (3,3,'D',last) -> "ABCABCD"; first copied byte 2 cycles after accept.
//  3. Overlap run: (0,0,'x') then (1,5,'y',last) -> "xxxxxxy". Also (2,5,..) after "ab" -> "ababa.."
//     (distance 1 and 2).
//  4. Backpressure: random out_ready (50% duty) during test 2 -> identical byte sequence, data stable
//     while stalled.
//  5. Wrap: stream 600 literals 0..599 mod 256, then (512,4,..) -> bytes equal to literals 88..91,
//     and wr_ptr has wrapped.
//  6. Errors/reset: first token (5,2,'z') -> err_token=1 and 3 bytes emitted. Assert rst mid-COPY ->
//     out_valid=0 immediately, err_token=0, next token decodes cleanly.

Source files
------------

// File: rtl/lz77_pkg.sv
// Shared LZ77 definitions: default widths used by encoder and decoder, and the decoder FSM encoding.
package lz77_pkg;
  localparam int LZ_DATA_WIDTH       = 8;
  localparam int LZ_DICT_DEPTH       = 512;
  localparam int LZ_DICT_DEPTH_LOG   = 9;
  localparam int LZ_LOOK_AHEAD_DEPTH = 66;
  localparam int LZ_CNT_WIDTH        = 7;
  // Distance field carries one extra bit so a full-window distance is representable.
  localparam int LZ_POS_WIDTH        = LZ_DICT_DEPTH_LOG + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_LIT  = 2'd2
  } lz77_state_e;
endpackage

// File: rtl/lz77_decoder_if.sv
// Token input stream, decoded byte output stream and error flag of the LZ77 decoder.
interface lz77_decoder_if
  import lz77_pkg::*;
#(
  parameter int DATA_WIDTH = LZ_DATA_WIDTH,
  parameter int POS_WIDTH  = LZ_POS_WIDTH,
  parameter int CNT_WIDTH  = LZ_CNT_WIDTH
);
  logic                  tok_valid;
  logic                  tok_ready;
  logic [POS_WIDTH-1:0]  tok_position;
  logic [CNT_WIDTH-1:0]  tok_length;
  logic [DATA_WIDTH-1:0] tok_next_symbol;
  logic                  tok_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  err_token;

  modport master (
    output tok_valid, tok_position, tok_length, tok_next_symbol, tok_last, out_ready,
    input  tok_ready, out_valid, out_data, out_last, err_token
  );

  modport slave (
    input  tok_valid, tok_position, tok_length, tok_next_symbol, tok_last, out_ready,
    output tok_ready, out_valid, out_data, out_last, err_token
  );
endinterface

// File: rtl/lz77_history_ram.sv
// Simple dual-port history window: synchronous write, registered read (read-before-write on collision).
module lz77_history_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/lz77_decoder.sv
// LZ77 token decoder: replays (distance, length) matches from a circular history, then the literal.
module lz77_decoder
  import lz77_pkg::*;
#(
  parameter int DATA_WIDTH           = LZ_DATA_WIDTH,
  parameter int DICTIONARY_DEPTH     = LZ_DICT_DEPTH,
  parameter int DICTIONARY_DEPTH_LOG = LZ_DICT_DEPTH_LOG,
  parameter int CNT_WIDTH            = LZ_CNT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  lz77_decoder_if.slave  dec_if
);
  localparam int AW = DICTIONARY_DEPTH_LOG;
  localparam int PW = DICTIONARY_DEPTH_LOG + 1;

  lz77_state_e           state_q;
  logic                  tok_ready_q;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [PW-1:0]         fill_q;
  logic                  tlast_q;
  logic                  err_q;
  logic                  out_valid_q, out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] sym_q, last_byte_q;
  logic                  byp_q;

  logic                  accept, out_free, copy_adv, lit_adv, we, tok_bad;
  logic [DATA_WIDTH-1:0] rdata, wdata;

  assign accept   = dec_if.tok_valid & tok_ready_q;
  assign out_free = ~out_valid_q | dec_if.out_ready;
  assign copy_adv = (state_q == ST_COPY) & out_free;
  assign lit_adv  = (state_q == ST_LIT) & out_free;
  assign we       = copy_adv | lit_adv;
  // Distance 1 reads the byte being written this very cycle, so take it from the bypass register.
  assign wdata    = copy_adv ? (byp_q ? last_byte_q : rdata) : sym_q;
  assign tok_bad  = (dec_if.tok_length != '0) &&
                    ((dec_if.tok_position == '0) || (dec_if.tok_position > fill_q));

  // Read address runs one step ahead so the RAM output always holds history[rd_ptr_q].
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (accept)        rd_ptr_d = wr_ptr_q - dec_if.tok_position[AW-1:0];
    else if (copy_adv) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  lz77_history_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_hist (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_d),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tok_ready_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      fill_q      <= '0;
      tlast_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (we) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (fill_q != PW'(DICTIONARY_DEPTH)) fill_q <= fill_q + 1'b1;
      end

      if (we) begin
        out_valid_q <= 1'b1;
        out_data_q  <= wdata;
        out_last_q  <= lit_adv & tlast_q;
      end else if (dec_if.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tok_ready_q <= 1'b0;
            tlast_q     <= dec_if.tok_last;
            cnt_q       <= dec_if.tok_length;
            if (tok_bad) err_q <= 1'b1;
            state_q     <= (dec_if.tok_length == '0) ? ST_LIT : ST_COPY;
          end else begin
            tok_ready_q <= 1'b1;
          end
        end
        ST_COPY: begin
          if (copy_adv) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_WIDTH'(1)) state_q <= ST_LIT;
          end
        end
        ST_LIT: begin
          if (lit_adv) begin
            state_q     <= ST_IDLE;
            tok_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sym_q <= dec_if.tok_next_symbol;
      byp_q <= (dec_if.tok_position == PW'(1));
    end
    if (we) last_byte_q <= wdata;
  end

  assign dec_if.tok_ready = tok_ready_q;
  assign dec_if.out_valid = out_valid_q;
  assign dec_if.out_data  = out_data_q;
  assign dec_if.out_last  = out_last_q;
  assign dec_if.err_token = err_q;
endmodule
